// File: rtl/arb_l0_n.sv
// -----------------------------------------------------------------------------
// arb_l0_n : level-0 bus demultiplexer, one master to NSLAVES slaves.
//
// The slave is picked by the address field m_addr[SEL_LSB +: SEL_W]. Selects
// with no slave behind them go to an internal error slave. That slave accepts
// at once and answers reads one cycle later with ERR_RDATA.
//
// Reads are returned in order. Only one target may hold outstanding reads at
// any time. A request to a different target waits until every read to the
// current target has returned.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous reset, active low
//   m_req    : master request
//   m_we     : master write enable (1 = write)
//   m_addr   : master address
//   m_be     : master byte enables
//   m_wdata  : master write data
//   m_ack    : request accepted this cycle
//   m_resp   : read data valid (one pulse per read)
//   m_rdata  : read data, zero when m_resp is low
//   s_req    : per-slave request, one bit per slave
//   s_we     : per-slave write enable (broadcast)
//   s_addr   : per-slave address (broadcast), slave k at [32k+31:32k]
//   s_be     : per-slave byte enables (broadcast), slave k at [4k+3:4k]
//   s_wdata  : per-slave write data (broadcast), slave k at [32k+31:32k]
//   s_ack    : per-slave accept
//   s_resp   : per-slave read response, single-cycle pulse
//   s_rdata  : per-slave read data, slave k at [32k+31:32k]
//
// Handshake: a master request completes in the cycle where m_req and m_ack
// are both high. m_ack is only asserted while m_req is high. The master holds
// its request stable until m_ack is seen. Read data comes back later as a
// single-cycle m_resp pulse, and m_resp has no ready or backpressure.
// -----------------------------------------------------------------------------
module arb_l0_n #(
   parameter int          NSLAVES   = 4,
   parameter int          SEL_W     = 3,
   parameter int          SEL_LSB   = 28,
   parameter int          MAX_OUT   = 4,
   parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    m_req,
   input  logic                    m_we,
   input  logic [31:0]             m_addr,
   input  logic [3:0]              m_be,
   input  logic [31:0]             m_wdata,
   output logic                    m_ack,
   output logic                    m_resp,
   output logic [31:0]             m_rdata,
   output logic [NSLAVES-1:0]      s_req,
   output logic [NSLAVES-1:0]      s_we,
   output logic [32*NSLAVES-1:0]   s_addr,
   output logic [4*NSLAVES-1:0]    s_be,
   output logic [32*NSLAVES-1:0]   s_wdata,
   input  logic [NSLAVES-1:0]      s_ack,
   input  logic [NSLAVES-1:0]      s_resp,
   input  logic [32*NSLAVES-1:0]   s_rdata
);

   // The target index is one bit wider than the select field. This lets the
   // error-slave index NSLAVES fit even when NSLAVES == 2**SEL_W.
   localparam int              TGT_W   = SEL_W + 1;
   localparam logic [TGT_W-1:0] ERR_IDX = TGT_W'(NSLAVES);
   localparam logic [3:0]       MAX_CNT = 4'(MAX_OUT);

   logic [3:0]       cnt;       // outstanding reads
   logic [TGT_W-1:0] cur;       // target that owns the outstanding reads
   logic             err_pend;  // error-slave read answer due this cycle

   logic [SEL_W-1:0] sel;
   logic [TGT_W-1:0] tgt;
   logic             allow;
   logic             tgt_ack;
   logic             cur_resp;
   logic [31:0]      cur_rdata;
   logic             cur_is_err;
   logic             rd_acc;
   logic             acc;

   assign sel = m_addr[SEL_LSB +: SEL_W];

   always_comb begin
      tgt = ERR_IDX;
      if ({1'b0, sel} < ERR_IDX) tgt = {1'b0, sel};
   end

   // The gate depends only on registered state and the request itself. That
   // keeps s_resp off every combinational path to s_req and m_ack.
   assign allow = rst_i
                & ((cnt == 4'd0) | (tgt == cur))
                & ~(~m_we & (cnt == MAX_CNT));

   // Request side: per-slave request plus the accept mux.
   always_comb begin
      tgt_ack = 1'b0;
      s_req   = '0;
      for (int k = 0; k < NSLAVES; k++) begin
         if (tgt == TGT_W'(k)) begin
            tgt_ack  = s_ack[k];
            s_req[k] = m_req & allow;
         end
      end
   end

   // The error slave accepts unconditionally.
   assign m_ack = m_req & allow & ((tgt == ERR_IDX) | tgt_ack);

   assign s_we    = {NSLAVES{m_we}};
   assign s_addr  = {NSLAVES{m_addr}};
   assign s_be    = {NSLAVES{m_be}};
   assign s_wdata = {NSLAVES{m_wdata}};

   // Response side: only the slave in cur is listened to.
   always_comb begin
      cur_resp  = 1'b0;
      cur_rdata = '0;
      for (int k = 0; k < NSLAVES; k++) begin
         if (cur == TGT_W'(k)) begin
            cur_resp  = s_resp[k];
            cur_rdata = s_rdata[32*k +: 32];
         end
      end
   end

   assign cur_is_err = (cur == ERR_IDX);

   // A response with cnt == 0 is stale (spurious, or from before a reset) and
   // is dropped here.
   assign m_resp  = rst_i & (cnt != 4'd0) & (cur_is_err ? err_pend : cur_resp);
   assign m_rdata = m_resp ? (cur_is_err ? ERR_RDATA : cur_rdata) : 32'h0;

   assign acc    = m_req & m_ack;
   assign rd_acc = acc & ~m_we;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt      <= 4'd0;
         cur      <= '0;
         err_pend <= 1'b0;
      end else begin
         if (acc) cur <= tgt;
         // An accept and a retire in the same cycle cancel out.
         if (rd_acc && !m_resp)      cnt <= cnt + 4'd1;
         else if (!rd_acc && m_resp) cnt <= cnt - 4'd1;
         err_pend <= rd_acc & (tgt == ERR_IDX);
      end
   end

endmodule
